// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin sequencer that shares one fixed-latency
// Fibonacci engine among NREQ requesters and returns tagged results.
module fib_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int FLUSH_CYC = 260
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_n,
  output logic [NREQ-1:0]   req_ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_fn,
  output logic              rsp_ovf,
  output logic              busy,
  output logic [7:0]        eng_n,
  output logic              eng_st,
  input  logic [31:0]       eng_fn
);

  localparam int FCW = $clog2(FLUSH_CYC + 2);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_RESPOND
  } state_t;

  state_t         state;
  state_t         state_d;
  logic [FCW-1:0] flush_cnt;
  logic [7:0]     wait_cnt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [7:0]     n_q;

  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [7:0]     gnt_n;
  int             idx;

  // Scan from the far end so the slot nearest the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_n   = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (1'(req >> idx)) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
        gnt_n   = 8'(req_n >> (8 * idx));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FLUSH;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_FLUSH:   if (flush_cnt <= FCW'(1)) state_d = S_IDLE;
      S_IDLE:    if (gnt_any) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT:    if (wait_cnt == 8'd0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESPOND;
      S_RESPOND: if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_FLUSH;
    endcase
  end

  always_comb begin
    req_ack   = '0;
    eng_st    = 1'b0;
    rsp_valid = (state == S_RESPOND);
    busy      = (state != S_IDLE);
    eng_n     = n_q;
    if (state == S_LAUNCH) begin
      eng_st  = 1'b1;
      req_ack = NREQ'(1) << id_q;
    end
  end

  // The wait count equals n, which lines CAPTURE up with edge E(n+1).
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= FCW'(FLUSH_CYC);
      wait_cnt  <= '0;
      ptr       <= '0;
      id_q      <= '0;
      n_q       <= '0;
      rsp_id    <= '0;
      rsp_fn    <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      if (state == S_FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FCW'(1);
      if (state == S_IDLE && gnt_any) begin
        id_q <= gnt_id;
        n_q  <= gnt_n;
      end
      if (state == S_LAUNCH)
        wait_cnt <= n_q;
      if (state == S_WAIT && wait_cnt != 8'd0)
        wait_cnt <= wait_cnt - 8'd1;
      if (state == S_CAPTURE) begin
        rsp_fn  <= eng_fn;
        rsp_id  <= id_q;
        rsp_ovf <= (n_q > 8'd47);
      end
      if (state == S_RESPOND && rsp_ready)
        ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
    end
  end

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: directed and random stimulus against a timed model
// of the arbiter contract plus a fixed-latency engine model.
module tb_fib_arbiter;
  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int FLUSH_CYC = 260;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_n = '0;
  logic [NREQ-1:0]   req_ack;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_fn;
  logic              rsp_ovf;
  logic              busy;
  logic [7:0]        eng_n;
  logic              eng_st;
  logic [31:0]       eng_fn = '0;

  fib_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n),
    .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_fn(rsp_fn),
    .rsp_ovf(rsp_ovf), .busy(busy), .eng_n(eng_n),
    .eng_st(eng_st), .eng_fn(eng_fn)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fib(input int n);
    logic [31:0] a = 0;
    logic [31:0] b = 1;
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] s;
    for (int k = 0; k < NREQ; k++) begin
      s = r >> ((p + k) % NREQ);
      if (s[0]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Engine: result garbage until n+1 edges after the start edge.
  int e_left = 0;
  int e_n = 0;
  always @(posedge clk) begin
    if (eng_st) begin
      e_n    <= int'(eng_n);
      e_left <= int'(eng_n) + 1;
      eng_fn <= $urandom;
    end else if (e_left > 1) begin
      e_left <= e_left - 1;
      eng_fn <= $urandom;
    end else if (e_left == 1) begin
      e_left <= 0;
      eng_fn <= fib(e_n);
    end
  end

  typedef struct {
    int          id;
    logic [31:0] fn;
    logic        ovf;
    int          lat;
  } rsp_t;

  rsp_t        log_q[$];
  int          cyc = 0;
  int          flush_end = 0;
  int          m_ptr = 0;
  bit          job_on = 0;
  int          job_t, job_id, job_n, first_v, d;
  logic [31:0] job_fn;

  // Reference: request sampled at cycle T -> ack at T+1, valid at T+n+4.
  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (rst) begin
      flush_end = cyc + 1 + FLUSH_CYC;
      job_on    = 0;
      m_ptr     = 0;
    end else if (cyc < flush_end) begin
      chk("flush_out", {busy, eng_st, rsp_valid, req_ack},
          {1'b1, 1'b0, 1'b0, {NREQ{1'b0}}});
    end else if (!job_on) begin
      chk("idle_out", {busy, eng_st, rsp_valid, req_ack}, '0);
      if (req != '0) begin
        job_on  = 1;
        job_t   = cyc;
        job_id  = rr_pick(req, m_ptr);
        job_n   = int'(req_n[8*job_id +: 8]);
        job_fn  = fib(job_n);
        first_v = -1;
      end
    end else begin
      d = cyc - job_t;
      if (rsp_valid && first_v < 0) first_v = d;
      chk("job_busy", busy, 1);
      chk("eng_n", eng_n, job_n);
      if (d == 1)
        chk("ack", {req_ack, eng_st}, {NREQ'(1) << job_id, 1'b1});
      else
        chk("no_ack", {req_ack, eng_st}, '0);
      if (d < job_n + 4) begin
        chk("rsp_early", rsp_valid, 0);
      end else begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_fn", rsp_fn, job_fn);
        chk("rsp_id", rsp_id, job_id);
        chk("rsp_ovf", rsp_ovf, job_n > 47);
        if (rsp_valid && rsp_ready) begin
          r.id  = int'(rsp_id);
          r.fn  = rsp_fn;
          r.ovf = rsp_ovf;
          r.lat = first_v;
          log_q.push_back(r);
          job_on = 0;
          m_ptr  = (job_id + 1) % NREQ;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int cnt = 0;
    tick();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    while (busy && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    chk("flush_len", cnt, FLUSH_CYC);
    chk("idle_zero", {req_ack, rsp_valid, rsp_id, rsp_fn, rsp_ovf,
                      eng_st, eng_n, busy}, '0);
  endtask

  task automatic send(input int id, input int n);
    int c = 0;
    req_n[8*id +: 8] = 8'(n);
    req[id] = 1'b1;
    @(negedge clk);
    while (!req_ack[id] && c < 400) begin
      c++;
      @(negedge clk);
    end
    chk("ack_seen", req_ack[id], 1);
    tick();
    req[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int want, input int lim);
    int c = 0;
    while (log_q.size() < want && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("rsp_arrived", log_q.size() >= want, 1);
  endtask

  task automatic job(input int id, input int n, input logic [31:0] fn,
                     input logic ovf);
    int base;
    base = log_q.size();
    tick();
    send(id, n);
    wait_rsp(base + 1, n + 40);
    if (log_q.size() > base) begin
      chk("job_id", log_q[base].id, id);
      chk("job_fn", log_q[base].fn, fn);
      chk("job_ovf", log_q[base].ovf, ovf);
      chk("job_lat", log_q[base].lat, n + 4);
    end
  endtask

  function automatic logic [7:0] rand_n();
    int k = $urandom_range(0, 15);
    if (k < 11) return 8'($urandom_range(0, 20));
    if (k < 15) return 8'($urandom_range(40, 60));
    return 8'd255;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base, c, cnt_ack, cnt_st, cnt_drop;
    logic [NREQ-1:0] acks;
    int exp_id[5];
    logic [31:0] exp_fn[5];
    exp_id = '{0, 1, 2, 3, 0};
    exp_fn = '{32'd5, 32'd8, 32'd13, 32'd21, 32'd5};

    do_reset();
    rsp_ready = 1'b1;

    job(2, 10, 32'd55, 1'b0);
    job(0, 0, 32'd0, 1'b0);
    job(0, 1, 32'd1, 1'b0);
    job(0, 47, 32'd2971215073, 1'b0);
    job(1, 48, 32'd512559680, 1'b1);

    // Round-robin with every requester continuously asking.
    do_reset();
    rsp_ready = 1'b1;
    base = log_q.size();
    tick();
    for (int i = 0; i < NREQ; i++) req_n[8*i +: 8] = 8'(i + 5);
    req = '1;
    for (int k = 0; k < 600 && log_q.size() < base + 5; k++) begin
      @(negedge clk);
      acks = req_ack;
      tick();
      req = ~acks;
    end
    req = '0;
    c = 0;
    while ((busy || log_q.size() < base + 5) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("rr_count", log_q.size() >= base + 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (log_q.size() > base + i) begin
        chk("rr_id", log_q[base+i].id, exp_id[i]);
        chk("rr_fn", log_q[base+i].fn, exp_fn[i]);
      end
    end

    // Backpressure with a second request from the same requester.
    rsp_ready = 1'b0;
    base = log_q.size();
    tick();
    send(1, 3);
    tick();
    req_n[15:8] = 8'd9;
    req[1] = 1'b1;
    c = 0;
    while (!rsp_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("bp_valid", rsp_valid, 1);
    cnt_ack = 0;
    cnt_st = 0;
    cnt_drop = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ack != '0) cnt_ack++;
      if (eng_st) cnt_st++;
      if (!rsp_valid) cnt_drop++;
    end
    chk("bp_acks", cnt_ack, 0);
    chk("bp_eng_st", cnt_st, 0);
    chk("bp_drop", cnt_drop, 0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_one_xfer", log_q.size(), base + 1);
    c = 0;
    while (!req_ack[1] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("bp_ack2", req_ack[1], 1);
    tick();
    req[1] = 1'b0;
    wait_rsp(base + 2, 60);
    if (log_q.size() > base + 1) begin
      chk("bp_fn1", log_q[base].fn, 32'd2);
      chk("bp_fn2", log_q[base+1].fn, 32'd34);
    end

    // Reset while a long job is in WAIT.
    base = log_q.size();
    tick();
    send(3, 200);
    repeat (50) @(negedge clk);
    do_reset();
    chk("rst_no_rsp", log_q.size(), base);
    job(0, 7, 32'd13, 1'b0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      acks = req_ack;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acks[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req_n[8*i +: 8] = rand_n();
          req[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    c = 0;
    while ((req != '0 || busy) && c < 3000) begin
      @(negedge clk);
      acks = req_ack;
      tick();
      req = req & ~acks;
      rsp_ready = 1'b1;
      c++;
    end
    @(negedge clk);
    chk("drain", {req, busy}, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fib_arbiter.md
# fib_arbiter

Round-robin arbiter and sequencer that shares one 32-bit Fibonacci engine among `NREQ` requesters. It accepts one request at a time and drives the engine's `n`/`st` inputs with a single-cycle start pulse. It counts the engine's fixed latency, since the engine has no done flag, captures the result and returns it with the requester ID over a valid/ready response port. It sits between the requester logic and the engine instance, and it is the only driver of the engine inputs.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `IDW`, 2, requester ID width; must satisfy `2**IDW >= NREQ`.
- `FLUSH_CYC`, 260, post-reset idle cycles with `eng_st` low. This guarantees the engine has returned to its idle state.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NREQ: per-requester request level; must be held until its `req_ack` bit pulses.
- `req_n` input NREQ*8: packed operand, requester i on bits `[8i+7:8i]`; must be stable while `req[i]` is high.
- `req_ack` output NREQ: one-cycle pulse on the granted requester's bit.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_id` output IDW: ID of the requester whose result is on `rsp_fn`.
- `rsp_fn` output 32: F(n) modulo 2^32.
- `rsp_ovf` output 1: set when n > 47 (the true F(n) exceeds 32 bits).
- `busy` output 1: high in every state except IDLE.
- `eng_n` output 8: engine operand.
- `eng_st` output 1: engine start pulse.
- `eng_fn` input 32: engine result register.

## Operation
- **States:** FLUSH, IDLE, LAUNCH, WAIT, CAPTURE, RESPOND.
- **Reset:** `rst` forces state FLUSH, the flush counter to `FLUSH_CYC`, and the round-robin pointer to 0. It also clears `req_ack`, `rsp_valid`, `rsp_id`, `rsp_fn`, `rsp_ovf`, `eng_st` and `eng_n`, and sets `busy`=1. The same applies to a reset asserted mid-operation: the in-flight request is dropped, with no ack re-issued and no response.
- **FLUSH:** decrement the counter. At 0, go to IDLE.
- **IDLE:** if any `req` bit is high, pick the first set bit at or after the pointer, wrapping modulo NREQ. Latch its ID into `id_q` and its operand into `n_q`, then go to LAUNCH. If no bit is set, stay in IDLE.
- **LAUNCH (one cycle):**
  - drive `eng_st`=1, `eng_n`=`n_q` and `req_ack[id_q]`=1;
  - load the wait counter with `n_q` (8-bit);
  - go to WAIT.
- **WAIT:**
  - `eng_st`=0; `eng_n` holds `n_q` throughout the job;
  - if the counter is non-zero, decrement it;
  - if the counter is 0, go to CAPTURE.
- **CAPTURE (one cycle):** `eng_fn` is valid this cycle. Register `rsp_fn`←`eng_fn`, `rsp_id`←`id_q` and `rsp_ovf`←(`n_q`>47), then go to RESPOND.
- **RESPOND:**
  - `rsp_valid`=1, with all response fields held stable;
  - when `rsp_valid`&`rsp_ready`: clear `rsp_valid`, set pointer←(`id_q`+1) mod NREQ, go to IDLE;
  - if `rsp_ready` stays low, remain in RESPOND indefinitely and do not start a new job.
- **Late requests:** a request arriving outside IDLE is not sampled until the next IDLE cycle. A `req` still high on return to IDLE counts as a new request.
- **Arithmetic:** `n`=0 gives 0 and `n`=1 gives 1. For n > 47, `rsp_fn` is the wrapped 32-bit value and `rsp_ovf`=1.

## Timing
- **Engine contract:** `st` is sampled on edge E0. The engine result is valid after edge E(n+1), and the engine is back to idle by then, so it can accept `st` again from that cycle.
- **Request to ack:** with request sampled in IDLE cycle T, `req_ack` is high in cycle T+1.
- **Request to response:** `rsp_valid` first goes high in cycle T+n+4.
- **Back-to-back jobs:** with `rsp_ready` held high, the next IDLE is T+n+5, giving a minimum job spacing of n+5 cycles.
- **Grant rotation:** the pointer advances only after a completed response. With all requests held, grants rotate 0,1,2,3,0…
- **Start pulse:** `eng_st` is never high for more than one cycle per job, and never high during FLUSH.

## Test plan
- **Reset/flush:** assert `rst` 2 cycles, release. Expect `busy`=1 and `eng_st`=0 for 260 cycles, then IDLE with all outputs 0.
- **Single request:** `req[2]`, `n`=10. Expect `req_ack`=4'b0100 one cycle later, then `rsp_valid` 14 cycles after sampling with `rsp_fn`=55, `rsp_id`=2, `rsp_ovf`=0.
- **Boundaries:**
  - `n`=0 → `rsp_fn`=0 after 4 cycles;
  - `n`=1 → 1;
  - `n`=47 → 2971215073 with `rsp_ovf`=0;
  - `n`=48 → 512559680 with `rsp_ovf`=1.
- **Round-robin:** all 4 `req` held high, `n`=i+5. Expect responses in order 0,1,2,3,0 with values 5, 8, 13, 21, and no starvation.
- **Backpressure:** `rsp_ready` low for 20 cycles with `req[1]` pending. Expect the response held stable, no second `req_ack`, and `eng_st` low, then one transfer when `rsp_ready` rises.
- **Mid-job reset:** `rst` during WAIT of an `n`=200 job. Expect no response, FLUSH re-entered, and the next request (`n`=7) to return 13.
